pipe_fetch_unit: RTL and testbench
==================================

Name: pipe_fetch_unit

Overview:
- IF stage of the pipelined CPU. It consumes the BranchMux/IfFlush redirect controls produced by the ID-stage control decoder.
- Owns the PC, the instruction-memory request handshake, a one-entry skid buffer and the IF/ID pipeline register.
- Supplies the instruction and PC+4 that the ID stage decodes.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_WORD, 32'h00000000, instruction word inserted into IF/ID on flush or bubble.
- COUNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- BranchMux  in  2  Next-PC select: 0=PC+4, 1=branch_target, 2=jump target, 3=treated as 0.
- IfFlush  in  1  Squash the IF/ID contents this cycle.
- stall  in  1  Hazard-unit stall: hold the PC and IF/ID.
- branch_target  in  32  Branch target computed in ID.
- imem_req  out  1  Instruction-memory request valid.
- imem_addr  out  32  Request address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  Response valid; imem_data is sampled on the same cycle.
- imem_data  in  32  Instruction word.
- pc  out  32  Current fetch PC.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  32  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0.
  - state=FETCH, skid buffer empty, req_addr=RESET_PC.
  - imem_req=0 while reset_n=0.
  - Reset mid-transaction abandons any outstanding request; memory must tolerate this.
- Redirect: redirect = (BranchMux==1 or BranchMux==2).
  - Target is branch_target for 1.
  - Target is {ifid_pc4[31:28], ifid_instr[25:0], 2'b00} for 2.
  - On redirect: pc<=target, IF/ID<=NOP_WORD with valid=0, skid cleared.
  - Redirect wins over stall and over an in-flight response.
- Flush: IfFlush=1 with no redirect loads NOP_WORD/valid=0 into IF/ID; pc is unchanged.
- The PC adder wraps modulo 2^32.
- State FETCH:
  - imem_req=1, imem_addr=pc; req_addr tracks pc.
  - imem_ready=1 and stall=0: IF/ID<=(imem_data, pc+4, valid=1), pc<=pc+4. Issue-to-IF/ID latency is 1 cycle when memory is zero-wait.
  - imem_ready=1 and stall=1: the word and pc+4 go into the skid buffer, pc<=pc+4, next state HOLD, IF/ID held.
  - imem_ready=0 and stall=0: IF/ID<=NOP_WORD with valid=0 (bubble).
  - imem_ready=0 and stall=1: IF/ID held.
  - Redirect with imem_ready=0: next state KILL; imem_addr stays req_addr (the old address).
  - Redirect with imem_ready=1: the returned word is discarded; stay in FETCH.
- State KILL:
  - imem_req=1, imem_addr=req_addr.
  - On imem_ready the word is dropped and the next state is FETCH, issuing the new pc.
  - Further redirects only update pc.
  - IF/ID follows the stall/bubble rules.
- State HOLD:
  - imem_req=0.
  - When stall falls: IF/ID<=skid contents (valid=1), skid cleared, next state FETCH.
  - Redirect in HOLD: skid dropped, next state FETCH.
- IfFlush and stall asserted together: the flush wins for IF/ID contents.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- When defined, adds three outputs, each COUNT_W bits wide:
  - redirect_cnt: counts cycles with a redirect.
  - bubble_cnt: counts cycles where IF/ID is loaded with NOP_WORD because of a memory wait.
  - stall_cnt: counts stall cycles.
- The counters saturate at all-ones and are cleared by reset_n.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release with zero-wait memory (imem_ready tied 1), 3 cycles → pc sequence 0,4,8,12; ifid_instr equals the words at 0,4,8; ifid_pc4=4,8,12; ifid_valid=1 from the first post-reset edge.
- BranchMux=1, branch_target=32'h100 for one cycle while pc=8 → next pc=32'h100; IF/ID=NOP_WORD, valid=0; next fetch address 32'h100.
- BranchMux=2 with ifid_pc4=32'h40000010 and ifid_instr[25:0]=26'h0000040 → pc=32'h40000100.
- imem_ready held low 2 cycles at pc=12, then redirect to 32'h200, then imem_ready=1 → imem_addr stays 12 until ready; that word is discarded; next request addr=32'h200; ifid_valid stays 0.
- stall=1 on a cycle where imem_ready=1 returns word W at pc=16 → state HOLD, imem_req=0, IF/ID unchanged; stall drops → ifid_instr=W, ifid_pc4=20, pc=20.
- Assert reset_n=0 asynchronously mid-KILL → pc=RESET_PC, imem_req=0 and ifid_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit -- IF stage of the pipelined CPU.
//
// Owns the fetch PC, the instruction-memory request handshake, a one-entry
// skid buffer and the IF/ID pipeline register. Consumes the BranchMux/IfFlush
// redirect controls from the ID-stage decoder and the hazard-unit stall.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset (sync release expected)
//   BranchMux[1:0] in   next-PC select: 0=PC+4, 1=branch_target, 2=jump, 3=PC+4
//   IfFlush        in   squash IF/ID this cycle
//   stall          in   hold PC and IF/ID
//   branch_target  in   branch target computed in ID
//   imem_req       out  instruction-memory request valid
//   imem_addr      out  request address (stable while req=1, ready=0)
//   imem_ready     in   response valid; imem_data sampled same cycle
//   imem_data      in   instruction word
//   pc             out  current fetch PC
//   ifid_instr     out  IF/ID instruction
//   ifid_pc4       out  IF/ID PC+4
//   ifid_valid     out  IF/ID holds a real instruction
//
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating COUNT_W-bit
// outputs redirect_cnt, bubble_cnt and stall_cnt.

module pipe_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  BranchMux,
  input  logic        IfFlush,
  input  logic        stall,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [COUNT_W-1:0] redirect_cnt,
  output logic [COUNT_W-1:0] bubble_cnt,
  output logic [COUNT_W-1:0] stall_cnt
`endif
);

  // FETCH: request at pc outstanding.
  // KILL : an abandoned request at req_addr is still outstanding; its word
  //        must be consumed and dropped before a new address can be issued.
  // HOLD : a word arrived under stall and waits in the skid buffer.
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_KILL  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state, state_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc4, skid_pc4_n;
  logic [31:0] pc_n;
  logic [31:0] ifid_instr_n;
  logic [31:0] ifid_pc4_n;
  logic        ifid_valid_n;
  logic        load_nop;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  always_comb begin
    redirect = (BranchMux == 2'd1) || (BranchMux == 2'd2);
    if (BranchMux == 2'd2) begin
      target = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};
    end else begin
      target = branch_target;
    end
    pc_plus4 = pc + 32'd4;
  end

  // The request is gated by reset_n directly so it drops the moment reset
  // asserts, independent of the clock.
  always_comb begin
    imem_req  = reset_n && (state != S_HOLD);
    imem_addr = (state == S_KILL) ? req_addr : pc;
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_addr_n   = req_addr;
    skid_instr_n = skid_instr;
    skid_pc4_n   = skid_pc4;
    ifid_instr_n = ifid_instr;
    ifid_pc4_n   = ifid_pc4;
    ifid_valid_n = ifid_valid;
    load_nop     = 1'b0;

    case (state)
      S_FETCH: begin
        req_addr_n = pc;
        if (redirect) begin
          pc_n     = target;
          load_nop = 1'b1;
          if (!imem_ready) begin
            state_n = S_KILL;
          end
        end else if (IfFlush) begin
          // Returned word is dropped with pc unchanged, so it is refetched.
          load_nop = 1'b1;
        end else if (imem_ready) begin
          pc_n = pc_plus4;
          if (stall) begin
            skid_instr_n = imem_data;
            skid_pc4_n   = pc_plus4;
            state_n      = S_HOLD;
          end else begin
            ifid_instr_n = imem_data;
            ifid_pc4_n   = pc_plus4;
            ifid_valid_n = 1'b1;
          end
        end else if (!stall) begin
          load_nop = 1'b1;
        end
      end

      S_KILL: begin
        if (imem_ready) begin
          state_n = S_FETCH;
        end
        if (redirect) begin
          pc_n     = target;
          load_nop = 1'b1;
        end else if (IfFlush || !stall) begin
          load_nop = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_n         = target;
          load_nop     = 1'b1;
          skid_instr_n = '0;
          skid_pc4_n   = '0;
          state_n      = S_FETCH;
        end else if (IfFlush) begin
          // Skid entry is kept: pc has already moved past it.
          load_nop = 1'b1;
        end else if (!stall) begin
          ifid_instr_n = skid_instr;
          ifid_pc4_n   = skid_pc4;
          ifid_valid_n = 1'b1;
          skid_instr_n = '0;
          skid_pc4_n   = '0;
          state_n      = S_FETCH;
        end
      end

      default: begin
        state_n = S_FETCH;
      end
    endcase

    if (load_nop) begin
      ifid_instr_n = NOP_WORD;
      ifid_pc4_n   = '0;
      ifid_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      skid_instr <= '0;
      skid_pc4   <= '0;
      ifid_instr <= NOP_WORD;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      skid_instr <= skid_instr_n;
      skid_pc4   <= skid_pc4_n;
      ifid_instr <= ifid_instr_n;
      ifid_pc4   <= ifid_pc4_n;
      ifid_valid <= ifid_valid_n;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // A bubble is a NOP load caused by waiting on memory: either a plain wait
  // in FETCH or draining an abandoned request in KILL.
  logic bubble;

  always_comb begin
    bubble = !redirect && !IfFlush && !stall &&
             ((state == S_KILL) || ((state == S_FETCH) && !imem_ready));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_cnt <= '0;
      bubble_cnt   <= '0;
      stall_cnt    <= '0;
    end else begin
      if (redirect && (redirect_cnt != '1)) begin
        redirect_cnt <= redirect_cnt + COUNT_W'(1);
      end
      if (bubble && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + COUNT_W'(1);
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + COUNT_W'(1);
      end
    end
  end
`else
  // COUNT_W only sizes the counter ports; referenced here so the default
  // build still uses it.
  if (COUNT_W == 0) begin : g_no_counters
  end
`endif

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed scoreboard bench for pipe_fetch_unit: expected IF/ID/pc triples are
// queued when stimulus is driven and compared after the following clock edge.

module tb_pipe_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [1:0]  BranchMux;
  logic        IfFlush;
  logic        stall;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  logic        ovr_en;
  logic [31:0] ovr_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  pipe_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(32'h0000_0000),
    .COUNT_W (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .BranchMux    (BranchMux),
    .IfFlush      (IfFlush),
    .stall        (stall),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  always_comb begin
    imem_data = ovr_en ? ovr_data : word_at(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_ifid(input logic [31:0] p, input logic [31:0] i,
                             input logic [31:0] q, input logic v);
    exp_t e;
    e.pc = p; e.instr = i; e.pc4 = q; e.valid = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] bm, input logic [31:0] tgt,
                       input logic fl, input logic st, input logic rdy);
    BranchMux = bm; branch_target = tgt; IfFlush = fl; stall = st; imem_ready = rdy;
  endtask

  // One clock edge, then pop the expectation queued for it.
  task automatic tick(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) e = sb.pop_front();
    else e = 'x;
    check({name, ".pc"},    pc,         e.pc);
    check({name, ".instr"}, ifid_instr, e.instr);
    check({name, ".pc4"},   ifid_pc4,   e.pc4);
    check({name, ".valid"}, 32'(ifid_valid), 32'(e.valid));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    ovr_en = 1'b0;
    ovr_data = '0;
    drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc", pc, 32'h0);
    check("rst.instr", ifid_instr, 32'h0);
    check("rst.pc4", ifid_pc4, 32'h0);
    check("rst.valid", 32'(ifid_valid), 32'd0);
    check("rst.req", 32'(imem_req), 32'd0);

    reset_n = 1'b1;
    #1;
    check("boot.req", 32'(imem_req), 32'd1);
    check("boot.addr", imem_addr, 32'h0);
    expect_ifid(32'h4, word_at(32'h0), 32'h4, 1'b1); tick("boot0");
    expect_ifid(32'h8, word_at(32'h4), 32'h8, 1'b1); tick("boot1");
    check("boot2.addr", imem_addr, 32'h8);

    // Branch at pc=8.
    drive(2'd1, 32'h100, 1'b0, 1'b0, 1'b1);
    expect_ifid(32'h100, 32'h0, 32'h0, 1'b0); tick("br");
    drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("br.addr", imem_addr, 32'h100);
    expect_ifid(32'h104, word_at(32'h100), 32'h104, 1'b1); tick("br_fetch");

    // Jump target built from ifid_pc4[31:28] and ifid_instr[25:0].
    drive(2'd1, 32'h4000_000C, 1'b0, 1'b0, 1'b1);
    expect_ifid(32'h4000_000C, 32'h0, 32'h0, 1'b0); tick("pre_j");
    drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    ovr_en = 1'b1; ovr_data = 32'h0800_0040;
    expect_ifid(32'h4000_0010, 32'h0800_0040, 32'h4000_0010, 1'b1); tick("j_src");
    ovr_en = 1'b0;
    drive(2'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    expect_ifid(32'h4000_0100, 32'h0, 32'h0, 1'b0); tick("jump");

    // Memory wait at pc=12, redirect while waiting, then drain.
    drive(2'd1, 32'hC, 1'b0, 1'b0, 1'b1);
    expect_ifid(32'hC, 32'h0, 32'h0, 1'b0); tick("to12");
    drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("wait0.addr", imem_addr, 32'hC);
    expect_ifid(32'hC, 32'h0, 32'h0, 1'b0); tick("wait0");
    check("wait1.addr", imem_addr, 32'hC);
    expect_ifid(32'hC, 32'h0, 32'h0, 1'b0); tick("wait1");
    drive(2'd1, 32'h200, 1'b0, 1'b0, 1'b0);
    expect_ifid(32'h200, 32'h0, 32'h0, 1'b0); tick("kill_in");
    drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("kill.addr", imem_addr, 32'hC);
    check("kill.req", 32'(imem_req), 32'd1);
    expect_ifid(32'h200, 32'h0, 32'h0, 1'b0); tick("kill_out");
    check("refetch.addr", imem_addr, 32'h200);
    expect_ifid(32'h204, word_at(32'h200), 32'h204, 1'b1); tick("after_kill");

    // Skid buffer at pc=16.
    drive(2'd1, 32'h10, 1'b0, 1'b0, 1'b1);
    expect_ifid(32'h10, 32'h0, 32'h0, 1'b0); tick("to16");
    drive(2'd0, 32'h0, 1'b0, 1'b1, 1'b1);
    expect_ifid(32'h14, 32'h0, 32'h0, 1'b0); tick("skid_in");
    check("hold.req", 32'(imem_req), 32'd0);
    expect_ifid(32'h14, 32'h0, 32'h0, 1'b0); tick("hold");
    drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    expect_ifid(32'h14, word_at(32'h10), 32'h14, 1'b1); tick("skid_out");
    check("skid_out.req", 32'(imem_req), 32'd1);
    check("skid_out.addr", imem_addr, 32'h14);

    // Flush, stall during wait, flush+stall.
    drive(2'd0, 32'h0, 1'b1, 1'b0, 1'b1);
    expect_ifid(32'h14, 32'h0, 32'h0, 1'b0); tick("flush");
    drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    expect_ifid(32'h18, word_at(32'h14), 32'h18, 1'b1); tick("post_flush");
    drive(2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_ifid(32'h18, word_at(32'h14), 32'h18, 1'b1); tick("stall_wait");
    drive(2'd0, 32'h0, 1'b1, 1'b1, 1'b1);
    expect_ifid(32'h18, 32'h0, 32'h0, 1'b0); tick("flush_stall");

    // PC adder wrap.
    drive(2'd1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
    expect_ifid(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0); tick("to_top");
    drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    expect_ifid(32'h0, word_at(32'hFFFF_FFFC), 32'h0, 1'b1); tick("wrap");

    // Redirect beats stall; memory not ready so the unit enters KILL.
    drive(2'd1, 32'h300, 1'b0, 1'b1, 1'b0);
    expect_ifid(32'h300, 32'h0, 32'h0, 1'b0); tick("br_stall");
    drive(2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("kill2.req", 32'(imem_req), 32'd1);

    // Asynchronous reset mid-KILL, away from any clock edge.
    #3;
    reset_n = 1'b0;
    #1;
    check("arst.pc", pc, 32'h0);
    check("arst.req", 32'(imem_req), 32'd0);
    check("arst.valid", 32'(ifid_valid), 32'd0);
    drive(2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    #1;
    expect_ifid(32'h4, word_at(32'h0), 32'h4, 1'b1); tick("reboot");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
